sha256_ctrl: RTL and testbench

Sequencer for the SHA-256 compression datapath `main_loop`. It accepts 512-bit chunk requests from the message-schedule front end and drives `main_loop`'s `clr_i`, `update_i` and `k_i`. It also issues per-round W requests to the schedule and captures the final digest. One round takes 4 cycles; a chunk of 64 rounds takes 256 cycles. Chunks of one message run back-to-back with no idle cycles.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_ctrl_if.sv | 10 +
 rtl/sha256_k_rom.sv | 9 +
 rtl/sha256_ctrl.sv | 115 +++++++++++
 tb/tb_sha256_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 round sequencer.
package sha256_pkg;
  localparam int NUM_ROUNDS   = 64;
  localparam int ROUND_CYCLES = 4;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, CAPTURE} state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [0:NUM_ROUNDS-1] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
endpackage

// File: rtl/sha256_ctrl_if.sv
// Chunk-request handshake between the message-schedule front end and the sequencer.
interface sha256_ctrl_if;
  logic in_valid_i;
  logic in_first_i;
  logic in_last_i;
  logic in_ready_o;

  modport master (output in_valid_i, in_first_i, in_last_i, input in_ready_o);
  modport slave  (input in_valid_i, in_first_i, in_last_i, output in_ready_o);
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  rnd,
  output logic [31:0] k
);
  assign k = K[rnd];
endmodule

// File: rtl/sha256_ctrl.sv
// Round sequencer for main_loop: 4 cycles per round, back-to-back chunks, digest capture.
module sha256_ctrl
  import sha256_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  sha256_ctrl_if.slave   req,
  output logic [5:0]     round_o,
  output logic           w_req_o,
  output logic [31:0]    k_o,
  output logic           clr_o,
  output logic           update_o,
  input  logic [255:0]   h_i,
  output logic [255:0]   digest_o,
  output logic           digest_valid_o,
  output logic           busy_o,
  output logic           err_o
);
  state_e      state;
  logic [5:0]  rnd;
  logic [1:0]  ph;
  logic        last_q, cont_q;
  logic [31:0] k_rd;

  sha256_k_rom u_rom (.rnd(round_o), .k(k_rd));

  assign k_o    = w_req_o ? k_rd : '0;
  assign busy_o = (state != IDLE);

  wire accept   = req.in_ready_o & req.in_valid_i;
  wire last_rnd = (rnd == 6'(NUM_ROUNDS - 1));
  wire ph_end   = (ph == 2'(ROUND_CYCLES - 1));

  // Outputs are registered: each branch decides what the next cycle drives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      rnd            <= '0;
      ph             <= '0;
      last_q         <= 1'b0;
      cont_q         <= 1'b0;
      req.in_ready_o <= 1'b0;
      round_o        <= '0;
      w_req_o        <= 1'b0;
      clr_o          <= 1'b0;
      update_o       <= 1'b0;
      err_o          <= 1'b0;
      digest_o       <= '0;
      digest_valid_o <= 1'b0;
    end else begin
      req.in_ready_o <= 1'b0;
      round_o        <= '0;
      w_req_o        <= 1'b0;
      clr_o          <= 1'b0;
      update_o       <= 1'b0;
      err_o          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && req.in_first_i) begin
            state          <= LAUNCH;
            last_q         <= req.in_last_i;
            digest_valid_o <= 1'b0;
            clr_o          <= 1'b1;
            w_req_o        <= 1'b1;
          end else begin
            req.in_ready_o <= 1'b1;
            if (accept) err_o <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= RUN;
          rnd   <= '0;
          ph    <= '0;
        end
        RUN: begin
          ph <= ph + 2'd1;
          if (ph_end) rnd <= rnd + 6'd1;
          // Continuation window opens on phase 2 of the final round.
          if (ph == 2'd1 && last_rnd && !last_q) req.in_ready_o <= 1'b1;
          if (ph == 2'd2) begin
            if (!last_rnd) begin
              w_req_o <= 1'b1;
              round_o <= rnd + 6'd1;
            end else begin
              update_o <= 1'b1;
              if (accept) begin
                cont_q  <= 1'b1;
                last_q  <= req.in_last_i;
                w_req_o <= 1'b1;
              end else if (!last_q) begin
                err_o <= 1'b1;
              end
            end
          end
          if (ph_end && last_rnd) begin
            rnd    <= '0;
            cont_q <= 1'b0;
            if (cont_q) state <= RUN;
            else if (last_q) state <= CAPTURE;
            else begin
              state          <= IDLE;
              req.in_ready_o <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          digest_o       <= h_i;
          digest_valid_o <= 1'b1;
          state          <= IDLE;
          req.in_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_ctrl.sv
// Bench: sha256_ctrl driving a behavioural SHA-256 compression/schedule model, digest scoreboard.
module tb_sha256_ctrl;
  logic         clk_i, rst_ni;
  logic [5:0]   round_o;
  logic         w_req_o, clr_o, update_o, digest_valid_o, busy_o, err_o;
  logic [31:0]  k_o;
  logic [255:0] h_i, digest_o;

  sha256_ctrl_if req_if();

  sha256_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req(req_if),
    .round_o(round_o), .w_req_o(w_req_o), .k_o(k_o), .clr_o(clr_o),
    .update_o(update_o), .h_i(h_i), .digest_o(digest_o),
    .digest_valid_o(digest_valid_o), .busy_o(busy_o), .err_o(err_o));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [255:0] IV_M = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0]  K0 = 32'h428a2f98;
  localparam logic [31:0]  K1 = 32'h71374491;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rnd_f(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  // main_loop + schedule model: rounds applied when W/K are presented.
  logic [31:0]  wtab [0:1][0:63];
  logic [255:0] hs, vs, hs_n, vs_n, h_add, base;
  logic         idx, idx_n;

  always_comb begin
    h_add = update_o ? add8(hs, vs) : hs;
    idx_n = clr_o ? 1'b0 : ((update_o && w_req_o) ? 1'b1 : idx);
    base  = clr_o ? IV_M : ((update_o && w_req_o) ? h_add : vs);
    vs_n  = w_req_o ? rnd_f(base, wtab[idx_n][round_o], k_o) : base;
    hs_n  = clr_o ? IV_M : h_add;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs <= '0; vs <= '0; idx <= 1'b0;
    end else begin
      hs <= hs_n; vs <= vs_n; idx <= idx_n;
    end
  end
  assign h_i = hs;

  int n_chk = 0, n_pass = 0;
  logic [255:0] sbq[$];
  wire [44:0] outs = {req_if.in_ready_o, w_req_o, round_o, k_o, clr_o, update_o, busy_o, err_o, digest_valid_o};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_msg(input string s);
    logic [7:0]  by [0:127];
    logic [31:0] w [0:63];
    logic [63:0] bits;
    int len, nb;
    len  = s.len();
    nb   = (len + 9 > 64) ? 2 : 1;
    bits = 64'(len) << 3;
    for (int i = 0; i < 128; i++) by[i] = 8'h00;
    for (int i = 0; i < len; i++) by[i] = s[i];
    by[len] = 8'h80;
    for (int j = 0; j < 8; j++) by[nb*64 - 1 - j] = bits[8*j +: 8];
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {by[b*64+4*t], by[b*64+4*t+1], by[b*64+4*t+2], by[b*64+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int t = 0; t < 64; t++) wtab[b][t] = w[t];
    end
  endtask

  // Accept a first chunk; returns in cycle L.
  task automatic send(input logic last, input logic push, input logic [255:0] expd);
    int w = 0;
    while (req_if.in_ready_o !== 1'b1 && w < 20) begin tick; w++; end
    chk("ready_before_send", 256'(req_if.in_ready_o), 256'(1));
    req_if.in_valid_i = 1'b1; req_if.in_first_i = 1'b1; req_if.in_last_i = last;
    if (push) sbq.push_back(expd);
    tick;
    req_if.in_valid_i = 1'b0; req_if.in_first_i = 1'b0; req_if.in_last_i = 1'b0;
  endtask

  // Walk a message from cycle L to its end, checking timing-critical cycles.
  task automatic walk(input int nch, input bit miss);
    int clr_n = 0, upd_bad = 0, err_n = 0;
    int endc = miss ? 257 : 256*nch + 2;
    chk("launch", 256'({clr_o, w_req_o, round_o, k_o, busy_o}), 256'({1'b1, 1'b1, 6'd0, K0, 1'b1}));
    for (int c = 1; c <= endc; c++) begin
      tick;
      req_if.in_valid_i = 1'b0; req_if.in_last_i = 1'b0;
      if (clr_o) clr_n++;
      if (update_o !== ((c % 256 == 0) && (c / 256 <= nch))) upd_bad++;
      if (err_o && !(miss && c == 256)) err_n++;
      if (c == 4) chk("round1_launch", 256'({w_req_o, round_o, k_o}), 256'({1'b1, 6'd1, K1}));
      if (c % 256 == 255) begin
        chk("window_ready", 256'(req_if.in_ready_o), 256'(miss || (c / 256 < nch - 1)));
        if (c / 256 < nch - 1) begin
          req_if.in_valid_i = 1'b1; req_if.in_first_i = 1'b0;
          req_if.in_last_i  = (c / 256 == nch - 2);
        end
      end
      if (c == 256 && nch == 2)
        chk("cont_launch", 256'({clr_o, w_req_o, round_o, k_o}), 256'({1'b0, 1'b1, 6'd0, K0}));
      if (miss && c == 256) chk("miss_err", 256'({err_o, update_o}), 256'(2'b11));
      if (miss && c == 257) chk("miss_idle", 256'({busy_o, digest_valid_o}), 256'(0));
      if (!miss && c == endc - 1) chk("capture", 256'({busy_o, digest_valid_o}), 256'(2'b10));
      if (!miss && c == endc) begin
        chk("done", 256'({busy_o, digest_valid_o}), 256'(2'b01));
        chk("sb_nonempty", 256'(sbq.size() != 0), 256'(1));
        if (sbq.size() != 0) chk("digest", digest_o, sbq.pop_front());
      end
    end
    chk("update_timing", 256'(upd_bad), 256'(0));
    chk("no_reclr", 256'(clr_n), 256'(0));
    chk("no_stray_err", 256'(err_n), 256'(0));
  endtask

  initial begin
    rst_ni = 1'b0;
    req_if.in_valid_i = 1'b0; req_if.in_first_i = 1'b0; req_if.in_last_i = 1'b0;
    repeat (2) tick;
    chk("reset_outs", 256'(outs), 256'(0));
    chk("reset_digest", digest_o, 256'(0));
    rst_ni = 1'b1;
    tick;
    chk("ready_after_reset", 256'({req_if.in_ready_o, busy_o}), 256'(2'b10));

    load_msg("abc");
    send(1'b1, 1'b1, D_ABC);
    walk(1, 1'b0);

    req_if.in_valid_i = 1'b1; req_if.in_first_i = 1'b0;
    tick;
    req_if.in_valid_i = 1'b0;
    chk("nofirst_err", 256'({err_o, clr_o, busy_o, digest_valid_o}), 256'(4'b1001));
    tick;
    chk("nofirst_after", 256'({err_o, busy_o, req_if.in_ready_o}), 256'(3'b001));

    load_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send(1'b0, 1'b1, D_TWO);
    walk(2, 1'b0);

    send(1'b0, 1'b0, '0);
    chk("miss_dv_clear", 256'(digest_valid_o), 256'(0));
    walk(1, 1'b1);

    load_msg("abc");
    send(1'b1, 1'b1, D_ABC);
    repeat (121) tick;
    rst_ni = 1'b0;
    #1;
    chk("midreset_outs", 256'(outs), 256'(0));
    chk("midreset_digest", digest_o, 256'(0));
    sbq.delete();
    tick;
    rst_ni = 1'b1;
    tick;
    chk("ready_after_midreset", 256'(req_if.in_ready_o), 256'(1));
    send(1'b1, 1'b1, D_ABC);
    walk(1, 1'b0);

    load_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send(1'b0, 1'b1, D_TWO);
    chk("b2b_hold_abc", digest_o, D_ABC);
    chk("b2b_dv_drop1", 256'(digest_valid_o), 256'(0));
    walk(2, 1'b0);
    load_msg("abc");
    send(1'b1, 1'b1, D_ABC);
    chk("b2b_hold_two", digest_o, D_TWO);
    chk("b2b_dv_drop2", 256'(digest_valid_o), 256'(0));
    walk(1, 1'b0);

    chk("sb_empty", 256'(sbq.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
